// File: rtl/dram_refill_pkg.sv
// Shared types for the DRAM refill engine: FSM state encoding and block-array type.
// The block type matches the engine's default geometry (WORD_W=32, BLOCK_WORDS=4).
package dram_refill_pkg;

  localparam int DRF_WORD_W      = 32;
  localparam int DRF_BLOCK_WORDS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_GAP,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_DONE
  } state_t;

  typedef logic [DRF_BLOCK_WORDS-1:0][DRF_WORD_W-1:0] block_t;

  function automatic logic is_wait(input state_t s);
    return (s == ST_WB_WAIT) || (s == ST_FILL_WAIT);
  endfunction

endpackage

// File: rtl/dram_refill_watchdog.sv
// Wait-state watchdog: counts cycles spent waiting for a DRAM acknowledge and
// flags expiry on the TIMEOUT_CYCLES-th consecutive wait cycle.
module dram_refill_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_in_wait,
  input  logic i_state_change,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Expiry forces a state change, so the count never passes TIMEOUT_CYCLES-1.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_state_change) begin
      r_cnt <= '0;
    end else if (i_in_wait) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = i_in_wait && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dram_refill_engine.sv
// Cache miss refill engine: optional dirty write-back, one gap cycle, then block fill.
// Optional acknowledge watchdog enabled by defining DRAM_REFILL_TIMEOUT_EN.
module dram_refill_engine
  import dram_refill_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int BLOCK_WORDS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 miss_valid,
  output logic                                 miss_ready,
  input  logic [ADDR_W-1:0]                    miss_addr,
  input  logic                                 wb_needed,
  input  logic [ADDR_W-1:0]                    wb_addr,
  input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]   wb_data,
  output logic                                 fill_valid,
  output logic [ADDR_W-1:0]                    fill_addr,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0]   fill_data,
  output logic                                 busy,
  output logic                                 timeout_err,
  output logic                                 dram_request,
  output logic [ADDR_W-1:0]                    dram_address,
  output logic                                 dram_we,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0]   dram_write_data,
  input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]   dram_read_data,
  input  logic                                 dram_acknowledge
);

  state_t                             r_state;
  state_t                             w_next_state;
  logic [ADDR_W-1:0]                  r_miss_addr;
  logic [ADDR_W-1:0]                  r_wb_addr;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] r_wb_data;
  logic [ADDR_W-1:0]                  r_fill_addr;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] r_fill_data;
  logic                               w_accept;
  logic                               w_fill_ack;
  logic                               w_expired;

  assign w_accept   = (r_state == ST_IDLE) && miss_valid;
  assign w_fill_ack = ((r_state == ST_FILL_REQ) || (r_state == ST_FILL_WAIT)) && dram_acknowledge;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Acknowledge takes priority over watchdog expiry in the wait states.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (miss_valid) w_next_state = wb_needed ? ST_WB_REQ : ST_FILL_REQ;
      ST_WB_REQ:    w_next_state = dram_acknowledge ? ST_GAP : ST_WB_WAIT;
      ST_WB_WAIT: begin
        if (dram_acknowledge)  w_next_state = ST_GAP;
        else if (w_expired)    w_next_state = ST_IDLE;
      end
      ST_GAP:       w_next_state = ST_FILL_REQ;
      ST_FILL_REQ:  w_next_state = dram_acknowledge ? ST_DONE : ST_FILL_WAIT;
      ST_FILL_WAIT: begin
        if (dram_acknowledge)  w_next_state = ST_DONE;
        else if (w_expired)    w_next_state = ST_IDLE;
      end
      ST_DONE:      w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even before the reset edge lands.
  always_comb begin
    miss_ready      = 1'b0;
    dram_request    = 1'b0;
    dram_we         = 1'b0;
    dram_address    = '0;
    dram_write_data = '0;
    fill_valid      = 1'b0;
    busy            = 1'b0;
    if (!reset) begin
      busy = (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: miss_ready = 1'b1;
        ST_WB_REQ, ST_WB_WAIT: begin
          dram_request    = (r_state == ST_WB_REQ);
          dram_we         = 1'b1;
          dram_address    = r_wb_addr;
          dram_write_data = r_wb_data;
        end
        ST_FILL_REQ, ST_FILL_WAIT: begin
          dram_request = (r_state == ST_FILL_REQ);
          dram_address = r_miss_addr;
        end
        ST_DONE: fill_valid = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_miss_addr <= '0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_fill_addr <= '0;
      r_fill_data <= '0;
    end else begin
      if (w_accept) begin
        r_miss_addr <= miss_addr;
        r_wb_addr   <= wb_needed ? wb_addr : '0;
        r_wb_data   <= wb_needed ? wb_data : '0;
      end
      if (w_fill_ack) begin
        r_fill_addr <= r_miss_addr;
        r_fill_data <= dram_read_data;
      end
    end
  end

  assign fill_addr = reset ? '0 : r_fill_addr;
  assign fill_data = reset ? '0 : r_fill_data;

`ifdef DRAM_REFILL_TIMEOUT_EN
  logic r_timeout_err;

  dram_refill_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_in_wait      (is_wait(r_state)),
    .i_state_change (w_next_state != r_state),
    .o_expired      (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_expired && !dram_acknowledge) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err && !reset;
`else
  logic w_unused_timeout;

  assign w_expired        = 1'b0;
  assign timeout_err      = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_dram_refill_engine.sv
// Directed plus randomized bench for dram_refill_engine; transaction timing is
// predicted from request/acknowledge latencies and compared cycle-accurately.
module tb_dram_refill_engine;
  import dram_refill_pkg::*;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          miss_valid, miss_ready, wb_needed;
  logic [AW-1:0] miss_addr, wb_addr, fill_addr, dram_address;
  block_t        wb_data, fill_data, dram_write_data, dram_read_data;
  logic          fill_valid, busy, timeout_err, dram_request, dram_we, dram_acknowledge;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dram_refill_engine #(
    .ADDR_W(AW), .WORD_W(WW), .BLOCK_WORDS(BW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .wb_needed(wb_needed), .wb_addr(wb_addr), .wb_data(wb_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .busy(busy), .timeout_err(timeout_err),
    .dram_request(dram_request), .dram_address(dram_address), .dram_we(dram_we),
    .dram_write_data(dram_write_data), .dram_read_data(dram_read_data),
    .dram_acknowledge(dram_acknowledge)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic block_t rand_blk();
    block_t b;
    for (int w = 0; w < BW; w++) b[w] = $urandom;
    return b;
  endfunction

  // Drives one miss and plays DRAM with the given ack latencies (0 = same cycle
  // as the request). Expected timing: first request in the cycle after accept;
  // fill request lwb+2 cycles after a write-back request; fill_valid lf+1 after.
  task automatic run_txn(input string name, input logic dirty, input logic [AW-1:0] ma,
                         input logic [AW-1:0] wa, input block_t wd, input block_t rd,
                         input int lwb, input int lf);
    int            req_cyc[2];
    logic          req_we[2];
    logic [AW-1:0] req_addr[2];
    block_t        req_wd[2];
    int            nreq = 0, fv_cyc = -1, nfv = 0, nbusy = 0, stab_err = 0, cnt = -1;
    logic          cur_we = 1'b0;
    logic [AW-1:0] fa = '0;
    block_t        fd = '0;
    int            exp_fillreq, exp_fv;
    for (int i = 0; i < 2; i++) begin
      req_cyc[i] = -1; req_we[i] = 1'bx; req_addr[i] = 'x; req_wd[i] = 'x;
    end
    check({name, ":ready"}, miss_ready, 1);
    miss_valid = 1'b1; wb_needed = dirty; miss_addr = ma; wb_addr = wa; wb_data = wd;
    step();
    miss_valid = 1'b0; wb_needed = 1'($urandom); miss_addr = $urandom; wb_addr = $urandom;
    wb_data = rand_blk();
    for (int k = 0; k < 200 && fv_cyc < 0; k++) begin
      if (busy) nbusy++;
      if (dram_request) begin
        if (nreq < 2) begin
          req_cyc[nreq] = k; req_we[nreq] = dram_we;
          req_addr[nreq] = dram_address; req_wd[nreq] = dram_write_data;
        end
        cur_we = dram_we;
        cnt = dram_we ? lwb : lf;
        nreq++;
      end else if (cnt >= 0 && nreq > 0 && nreq <= 2) begin
        if (dram_address !== req_addr[nreq-1] || dram_we !== req_we[nreq-1] ||
            dram_write_data !== req_wd[nreq-1]) stab_err++;
      end
      if (fill_valid) begin
        fv_cyc = k; nfv++; fa = fill_addr; fd = fill_data;
      end
      if (cnt == 0) begin
        dram_acknowledge = 1'b1;
        dram_read_data = cur_we ? rand_blk() : rd;
        cnt = -1;
      end else begin
        dram_acknowledge = (cnt < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        dram_read_data = rand_blk();
        if (cnt > 0) cnt--;
      end
      step();
    end
    dram_acknowledge = 1'b0;
    exp_fillreq = dirty ? lwb + 2 : 0;
    exp_fv      = exp_fillreq + lf + 1;
    check({name, ":nreq"}, nreq, dirty ? 2 : 1);
    check({name, ":req0_cyc"}, req_cyc[0], 0);
    check({name, ":req0_we"}, req_we[0], dirty);
    check({name, ":req0_addr"}, req_addr[0], dirty ? wa : ma);
    if (dirty) begin
      check({name, ":wb_data"}, req_wd[0], wd);
      check({name, ":req1_cyc"}, req_cyc[1], exp_fillreq);
      check({name, ":req1_we"}, req_we[1], 0);
      check({name, ":req1_addr"}, req_addr[1], ma);
    end
    check({name, ":stable"}, stab_err, 0);
    check({name, ":fv_cyc"}, fv_cyc, exp_fv);
    check({name, ":nfv"}, nfv, 1);
    check({name, ":fill_addr"}, fa, ma);
    check({name, ":fill_data"}, fd, rd);
    check({name, ":busy_cycles"}, nbusy, exp_fv + 1);
    check({name, ":after"}, {fill_valid, miss_ready, busy}, 3'b010);
    check({name, ":hold_data"}, fill_data, rd);
  endtask

  initial begin
    block_t        bd;
    int            nfv, nbusy, nerr, k_err;
    logic [AW-1:0] a_a, a_b;

    reset = 1'b1; miss_valid = 1'b0; wb_needed = 1'b0; miss_addr = '0; wb_addr = '0;
    wb_data = '0; dram_read_data = '0; dram_acknowledge = 1'b0;
    @(negedge clk);
    step();
    check("reset:ctrl", {dram_request, dram_we, fill_valid, busy, miss_ready, timeout_err}, 0);
    check("reset:data", {dram_address, fill_addr}, 0);
    check("reset:blocks", {dram_write_data, fill_data}, 0);
    reset = 1'b0;
    #1;
    check("post_reset:ready", {miss_ready, busy, fill_valid}, 3'b100);
    @(negedge clk);

    bd = {32'd1, 32'd2, 32'd3, 32'd4};
    run_txn("clean", 1'b0, 32'h40, 32'h0, '0, bd, 0, 5);
    run_txn("dirty", 1'b1, 32'h40, 32'h80, {32'hA, 32'hB, 32'hC, 32'hD}, rand_blk(), 3, 2);
    run_txn("same_cycle_ack", 1'b1, 32'h1C0, 32'h2C0, rand_blk(), rand_blk(), 0, 0);
    for (int t = 0; t < 8; t++) begin
      run_txn("random", 1'($urandom), $urandom, $urandom, rand_blk(), rand_blk(),
              $urandom_range(0, 4), $urandom_range(0, 4));
    end

    // Reset while waiting for a fill acknowledge.
    miss_valid = 1'b1; wb_needed = 1'b0; miss_addr = 32'h100;
    step();
    miss_valid = 1'b0;
    step();
    step();
    check("rst_mid:busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("rst_mid:ctrl", {dram_request, dram_we, fill_valid, busy, miss_ready, timeout_err}, 0);
    check("rst_mid:data", {dram_address, fill_addr, dram_write_data, fill_data}, 0);
    step();
    reset = 1'b0; dram_acknowledge = 1'b1;
    #1;
    check("rst_mid:idle", {miss_ready, busy}, 2'b10);
    nfv = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (fill_valid) nfv++;
    end
    check("rst_mid:no_fill", nfv, 0);
    dram_acknowledge = 1'b0;

`ifdef DRAM_REFILL_TIMEOUT_EN
    miss_valid = 1'b1; wb_needed = 1'b0; miss_addr = 32'h200;
    step();
    miss_valid = 1'b0;
    k_err = -1; nfv = 0; nerr = 0;
    for (int k = 0; k < 41; k++) begin
      if (timeout_err && k_err < 0) k_err = k;
      if (timeout_err) nerr++;
      if (fill_valid) nfv++;
      step();
    end
    check("timeout:cycle", k_err, 9);
    check("timeout:sticky", nerr, 32);
    check("timeout:no_fill", nfv, 0);
    check("timeout:idle", {miss_ready, busy, timeout_err}, 3'b101);
    run_txn("after_timeout", 1'b0, 32'h240, 32'h0, '0, rand_blk(), 0, 1);
    check("timeout:still_set", timeout_err, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("timeout:cleared", timeout_err, 0);
    @(negedge clk);
`else
    miss_valid = 1'b1; wb_needed = 1'b0; miss_addr = 32'h200;
    step();
    miss_valid = 1'b0;
    nbusy = 0; nerr = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy && !miss_ready) nbusy++;
      if (timeout_err) nerr++;
      step();
    end
    check("no_wd:waiting", nbusy, 40);
    check("no_wd:no_err", nerr, 0);
    bd = rand_blk();
    dram_acknowledge = 1'b1; dram_read_data = bd;
    step();
    dram_acknowledge = 1'b0; dram_read_data = rand_blk();
    check("no_wd:fill", {fill_valid, fill_addr}, {1'b1, 32'h200});
    check("no_wd:fill_data", fill_data, bd);
    step();
`endif

    // Spurious acknowledges while idle.
    dram_acknowledge = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_ack", {miss_ready, busy, dram_request, fill_valid}, 4'b1000);
    end
    dram_acknowledge = 1'b0;

    // miss_valid held through a transfer: the second miss waits for IDLE.
    a_a = 32'h300; a_b = 32'h340; bd = rand_blk();
    miss_valid = 1'b1; wb_needed = 1'b0; miss_addr = a_a;
    step();
    check("held:req_a", {dram_request, dram_we, dram_address}, {2'b10, a_a});
    miss_addr = a_b; dram_acknowledge = 1'b1; dram_read_data = bd;
    step();
    dram_acknowledge = 1'b0;
    check("held:fill_a", {fill_valid, miss_ready, fill_addr}, {2'b10, a_a});
    step();
    check("held:idle", {miss_ready, dram_request}, 2'b10);
    step();
    check("held:req_b", {dram_request, dram_address}, {1'b1, a_b});
    miss_valid = 1'b0; dram_acknowledge = 1'b1;
    step();
    dram_acknowledge = 1'b0;
    check("held:fill_b", {fill_valid, fill_addr}, {1'b1, a_b});
    step();
    check("held:end", {miss_ready, busy}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
